// File: rtl/rom_access_ctrl.sv
// rom_access_ctrl: shares the program ROM data-read and write ports between the core load path and the UART loader
//   core_*   : core read requests (grant, rvalid, rdata)
//   ld_*     : loader session flag and read/write requests (grant, rvalid, rdata)
//   rom_*    : ROM write port and data-side read port (read data one cycle after address)
//   cpu_hold_o / prog_active_o : core stall and programming-state flags
//   wr_count_o / checksum_o    : words written and their wrapping sum for the current/last session
module rom_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [DATA_W-1:0] core_rdata_o,
  input  logic              ld_session_i,
  input  logic              ld_req_i,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_wdata_i,
  output logic              ld_gnt_o,
  output logic              ld_rvalid_o,
  output logic [DATA_W-1:0] ld_rdata_o,
  output logic              rom_wr_en_o,
  output logic [ADDR_W-1:0] rom_wr_addr_o,
  output logic [DATA_W-1:0] rom_wr_data_o,
  output logic [ADDR_W-1:0] rom_rd_addr_o,
  input  logic [DATA_W-1:0] rom_rd_data_i,
  output logic              cpu_hold_o,
  output logic              prog_active_o,
  output logic [CNT_W-1:0]  wr_count_o,
  output logic [DATA_W-1:0] checksum_o
);
  typedef enum logic [1:0] {IDLE, HOLD, PROG, RELEASE} state_t;
  state_t            state;
  logic              rr_ld;
  logic              ld_rd;
  logic              ld_rd_gnt;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] core_rdata_q;
  logic [DATA_W-1:0] ld_rdata_q;
  // rr_ld set means the loader wins the next tie; grants are masked while rst is high so outputs read 0 in reset
  always_comb begin
    ld_rd         = ld_req_i & ~ld_we_i;
    core_gnt_o    = ~rst & (state == IDLE) & core_req_i & ~(ld_rd & rr_ld);
    ld_gnt_o      = ~rst & ((state == PROG) ? ld_req_i : (state == IDLE) & ld_rd & ~(core_req_i & ~rr_ld));
    ld_rd_gnt     = ld_gnt_o & ~ld_we_i;
    rom_wr_en_o   = ld_gnt_o & ld_we_i;
    rom_wr_addr_o = rom_wr_en_o ? ld_addr_i : '0;
    rom_wr_data_o = rom_wr_en_o ? ld_wdata_i : '0;
    rom_rd_addr_o = core_gnt_o ? core_addr_i : ld_rd_gnt ? ld_addr_i : rd_addr_q;
    core_rdata_o  = core_rvalid_o ? rom_rd_data_i : core_rdata_q;
    ld_rdata_o    = ld_rvalid_o ? rom_rd_data_i : ld_rdata_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cpu_hold_o    <= 1'b0;
      prog_active_o <= 1'b0;
      rr_ld         <= 1'b0;
      rd_addr_q     <= '0;
      core_rvalid_o <= 1'b0;
      ld_rvalid_o   <= 1'b0;
      core_rdata_q  <= '0;
      ld_rdata_q    <= '0;
      wr_count_o    <= '0;
      checksum_o    <= '0;
    end else begin
      rd_addr_q     <= rom_rd_addr_o;
      core_rvalid_o <= core_gnt_o;
      ld_rvalid_o   <= ld_rd_gnt;
      if (core_rvalid_o) core_rdata_q <= rom_rd_data_i;
      if (ld_rvalid_o) ld_rdata_q <= rom_rd_data_i;
      if (core_gnt_o | ld_gnt_o) rr_ld <= core_gnt_o;
      if (state == HOLD && !core_rvalid_o) begin
        wr_count_o <= '0;
        checksum_o <= '0;
      end else if (rom_wr_en_o) begin
        wr_count_o <= (&wr_count_o) ? wr_count_o : wr_count_o + CNT_W'(1);
        checksum_o <= checksum_o + ld_wdata_i;
      end
      // HOLD waits out a core read granted in the last IDLE cycle before handing the port to the loader
      case (state)
        IDLE: if (ld_session_i) begin
          state      <= HOLD;
          cpu_hold_o <= 1'b1;
        end
        HOLD: if (!core_rvalid_o) begin
          state         <= PROG;
          prog_active_o <= 1'b1;
        end
        PROG: if (!ld_session_i) begin
          state         <= RELEASE;
          prog_active_o <= 1'b0;
        end
        RELEASE: begin
          state      <= IDLE;
          cpu_hold_o <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          cpu_hold_o    <= 1'b0;
          prog_active_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rom_access_ctrl.sv
// tb_rom_access_ctrl: directed and randomized checks of rom_access_ctrl against a ROM model and reference memory
module tb_rom_access_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req = 1'b0;
  logic [31:0] core_addr = '0;
  logic        core_gnt, core_rvalid;
  logic [31:0] core_rdata;
  logic        ld_session = 1'b0, ld_req = 1'b0, ld_we = 1'b0;
  logic [31:0] ld_addr = '0, ld_wdata = '0;
  logic        ld_gnt, ld_rvalid;
  logic [31:0] ld_rdata;
  logic        rom_wr_en;
  logic [31:0] rom_wr_addr, rom_wr_data, rom_rd_addr;
  logic [31:0] rom_rd_data = '0;
  logic        cpu_hold, prog_active;
  logic [15:0] wr_count;
  logic [31:0] checksum;
  int errors = 0;
  int checks = 0;
  logic [31:0] mem [0:255];
  logic [31:0] refmem [0:255];

  rom_access_ctrl dut (
    .clk(clk), .rst(rst),
    .core_req_i(core_req), .core_addr_i(core_addr), .core_gnt_o(core_gnt),
    .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
    .ld_session_i(ld_session), .ld_req_i(ld_req), .ld_we_i(ld_we),
    .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata), .ld_gnt_o(ld_gnt),
    .ld_rvalid_o(ld_rvalid), .ld_rdata_o(ld_rdata),
    .rom_wr_en_o(rom_wr_en), .rom_wr_addr_o(rom_wr_addr), .rom_wr_data_o(rom_wr_data),
    .rom_rd_addr_o(rom_rd_addr), .rom_rd_data_i(rom_rd_data),
    .cpu_hold_o(cpu_hold), .prog_active_o(prog_active),
    .wr_count_o(wr_count), .checksum_o(checksum)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return (i == 4) ? 32'hDEADBEEF : 32'h9E3779B1 * i + 32'h12345678;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (rom_wr_en) mem[rom_wr_addr[9:2]] <= rom_wr_data;
      rom_rd_data <= mem[rom_rd_addr[9:2]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string t);
    chk({t, "_flags"}, {core_gnt, ld_gnt, core_rvalid, ld_rvalid, rom_wr_en, cpu_hold, prog_active}, 0);
    chk({t, "_core_rdata"}, core_rdata, 0);
    chk({t, "_ld_rdata"}, ld_rdata, 0);
    chk({t, "_rd_addr"}, rom_rd_addr, 0);
    chk({t, "_wr_addr"}, rom_wr_addr, 0);
    chk({t, "_wr_data"}, rom_wr_data, 0);
    chk({t, "_count"}, wr_count, 0);
    chk({t, "_checksum"}, checksum, 0);
  endtask

  initial begin
    bit          cq, lq, pref_ld, exp_cv, exp_lv, eg_c, eg_l, we;
    logic [7:0]  ci, li;
    logic [31:0] exp_cd, exp_ld, w, sum;
    logic [15:0] cnt;
    for (int i = 0; i < 256; i++) refmem[i] = init_word(i);
    tick;
    #3 all_zero("reset");
    rst = 1'b0;
    tick;
    // single core read of word 4
    core_req = 1'b1; core_addr = 32'h10;
    #3 chk("t1_gnt", {core_gnt, ld_gnt}, 2'b10);
    chk("t1_rd_addr", rom_rd_addr, 32'h10);
    tick;
    core_req = 1'b0;
    #3 chk("t1_rvalid", {core_rvalid, ld_rvalid}, 2'b10);
    chk("t1_rdata", core_rdata, 32'hDEADBEEF);
    tick;
    #3 chk("t1_rvalid_drop", core_rvalid, 0);
    chk("t1_rdata_hold", core_rdata, 32'hDEADBEEF);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    // simultaneous held reads alternate starting with the core
    core_req = 1'b1; core_addr = 32'h20;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h40;
    for (int i = 0; i < 4; i++) begin
      #3 chk($sformatf("t2_gnt%0d", i), {core_gnt, ld_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (i > 0) chk($sformatf("t2_rv%0d", i), {core_rvalid, ld_rvalid}, (i % 2 == 1) ? 2'b10 : 2'b01);
      if (i == 1) chk("t2_core_rdata", core_rdata, refmem[8]);
      if (i == 2) chk("t2_ld_rdata", ld_rdata, refmem[16]);
      tick;
    end
    core_req = 1'b0; ld_req = 1'b0;
    #3 chk("t2_rv_last", {core_rvalid, ld_rvalid}, 2'b01);
    tick;
    // loader write waits in IDLE, then a session programs three words
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h0; ld_wdata = 32'h1;
    #3 chk("t4_idle_wr", {ld_gnt, rom_wr_en}, 0);
    tick;
    ld_session = 1'b1;
    #3 chk("t4_sess_idle", {ld_gnt, cpu_hold}, 0);
    tick;
    #3 chk("t4_hold", {cpu_hold, prog_active, ld_gnt}, 3'b100);
    tick;
    #3 chk("t4_prog", {cpu_hold, prog_active, ld_gnt, rom_wr_en}, 4'hF);
    chk("t4_wr_addr", rom_wr_addr, 0);
    chk("t4_wr_data", rom_wr_data, 1);
    chk("t4_cnt0", {wr_count, checksum}, 0);
    refmem[0] = 32'h1;
    tick;
    ld_addr = 32'h4; ld_wdata = 32'hFFFFFFFF;
    #3 chk("t4_w2", {ld_gnt, rom_wr_en, wr_count, checksum}, {2'b11, 16'd1, 32'h1});
    refmem[1] = 32'hFFFFFFFF;
    tick;
    ld_addr = 32'h8; ld_wdata = 32'h5;
    #3 chk("t4_w3", {ld_gnt, rom_wr_en}, 2'b11);
    refmem[2] = 32'h5;
    tick;
    ld_we = 1'b0; ld_addr = 32'h8;
    #3 chk("t4_r8", {ld_gnt, rom_wr_en}, 2'b10);
    chk("t4_rd_addr", rom_rd_addr, 32'h8);
    chk("t4_count", wr_count, 3);
    chk("t4_checksum", checksum, 32'h5);
    tick;
    ld_addr = 32'h4;
    #3 chk("t4_r4_gnt", ld_gnt, 1);
    chk("t4_rdata8", {ld_rvalid, ld_rdata}, {1'b1, 32'h5});
    tick;
    ld_req = 1'b0; ld_session = 1'b0; core_req = 1'b1; core_addr = 32'h10;
    #3 chk("t4_rdata4", {ld_rvalid, ld_rdata}, {1'b1, 32'hFFFFFFFF});
    chk("t4_prog_core", {core_gnt, prog_active}, 2'b01);
    tick;
    #3 chk("t4_release", {cpu_hold, prog_active, core_gnt, ld_gnt, ld_rvalid}, 5'b10000);
    chk("t4_rel_hold", {wr_count, ld_rdata}, {16'd3, 32'hFFFFFFFF});
    tick;
    // core read granted as the session rises stretches HOLD to two cycles
    ld_session = 1'b1;
    #3 chk("t5_idle_gnt", {cpu_hold, core_gnt}, 2'b01);
    tick;
    core_addr = 32'h14;
    #3 chk("t5_hold1", {cpu_hold, prog_active, core_gnt, core_rvalid}, 4'b1001);
    chk("t5_rdata", core_rdata, 32'hDEADBEEF);
    tick;
    #3 chk("t5_hold2", {cpu_hold, prog_active, core_gnt}, 3'b100);
    chk("t5_cnt_kept", wr_count, 3);
    tick;
    ld_session = 1'b0;
    #3 chk("t5_prog", {cpu_hold, prog_active, core_gnt}, 3'b110);
    chk("t5_cleared", {wr_count, checksum}, 0);
    tick;
    #3 chk("t5_release", {cpu_hold, core_gnt}, 2'b10);
    tick;
    #3 chk("t5_idle", {cpu_hold, core_gnt}, 2'b01);
    chk("t5_rd_addr", rom_rd_addr, 32'h14);
    tick;
    core_req = 1'b0;
    #3 chk("t5_rv", {core_rvalid, core_rdata}, {1'b1, refmem[5]});
    tick;
    // reset during PROG with a loader read in flight
    ld_session = 1'b1;
    for (int k = 0; k < 10 && !prog_active; k++) tick;
    chk("t6_prog_reached", prog_active, 1);
    w = $urandom;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'hC; ld_wdata = w;
    #3 chk("t6_wr", {ld_gnt, rom_wr_en}, 2'b11);
    refmem[3] = w;
    tick;
    ld_we = 1'b0;
    #3 chk("t6_rd", ld_gnt, 1);
    tick;
    rst = 1'b1; ld_req = 1'b0; ld_session = 1'b0;
    #3 all_zero("t6_rst");
    rst = 1'b0;
    tick;
    #3 chk("t6_after", {cpu_hold, prog_active, ld_rvalid, wr_count}, 0);
    tick;
    // randomized IDLE arbitration against round-robin reference
    cq = 0; lq = 0; pref_ld = 0; exp_cv = 0; exp_lv = 0; exp_cd = '0; exp_ld = '0; ci = '0; li = '0;
    for (int n = 0; n < 300; n++) begin
      if (!cq && $urandom_range(1) == 1) begin cq = 1; ci = 8'($urandom); end
      if (!lq && $urandom_range(1) == 1) begin lq = 1; li = 8'($urandom); end
      core_req = cq; core_addr = {22'b0, ci, 2'b00};
      ld_req = lq; ld_we = 1'b0; ld_addr = {22'b0, li, 2'b00};
      eg_c = cq && !(lq && pref_ld);
      eg_l = lq && !eg_c;
      #3 chk("rnd_gnt", {core_gnt, ld_gnt}, {eg_c, eg_l});
      chk("rnd_rv", {core_rvalid, ld_rvalid}, {exp_cv, exp_lv});
      if (exp_cv) chk("rnd_core_rdata", core_rdata, exp_cd);
      if (exp_lv) chk("rnd_ld_rdata", ld_rdata, exp_ld);
      exp_cv = eg_c; exp_cd = refmem[ci];
      exp_lv = eg_l; exp_ld = refmem[li];
      if (eg_c || eg_l) pref_ld = eg_c;
      if (eg_c) cq = 0;
      if (eg_l) lq = 0;
      tick;
    end
    core_req = 1'b0; ld_req = 1'b0;
    tick;
    // randomized programming session against a memory/count/sum reference
    ld_session = 1'b1;
    for (int k = 0; k < 10 && !prog_active; k++) tick;
    chk("rs_prog_reached", prog_active, 1);
    cnt = '0; sum = '0; exp_lv = 0; exp_ld = '0;
    core_req = 1'b1; core_addr = 32'h30;
    for (int n = 0; n < 200; n++) begin
      lq = ($urandom_range(3) != 0);
      we = $urandom_range(1);
      li = 8'($urandom);
      w = $urandom;
      ld_req = lq; ld_we = we; ld_addr = {22'b0, li, 2'b00}; ld_wdata = w;
      #3 chk("rs_gnt", {core_gnt, ld_gnt, rom_wr_en}, {1'b0, lq, lq && we});
      chk("rs_rv", ld_rvalid, exp_lv);
      if (exp_lv) chk("rs_rdata", ld_rdata, exp_ld);
      chk("rs_count", wr_count, cnt);
      chk("rs_sum", checksum, sum);
      exp_lv = lq && !we;
      exp_ld = refmem[li];
      if (lq && we) begin
        refmem[li] = w;
        cnt++;
        sum += w;
      end
      tick;
    end
    ld_req = 1'b0; ld_session = 1'b0;
    #3 chk("rs_last_rv", ld_rvalid, exp_lv);
    if (exp_lv) chk("rs_last_rdata", ld_rdata, exp_ld);
    tick;
    #3 chk("rs_release", {cpu_hold, prog_active, core_gnt}, 3'b100);
    chk("rs_final", {wr_count, checksum}, {cnt, sum});
    tick;
    #3 chk("rs_idle", {cpu_hold, core_gnt}, 2'b01);
    tick;
    core_req = 1'b0;
    #3 chk("rs_core_rv", {core_rvalid, core_rdata}, {1'b1, refmem[12]});
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
